// File: rtl/mm_refill_responder_pkg.sv
// -----------------------------------------------------------------------------
// mm_refill_responder_pkg
//   Shared definitions for the main-memory refill responder:
//   - state_e      : FSM state encoding (IDLE/WAIT/RESP/COOL)
//   - BLOCK_WORDS  : words per refill block
//   - CNT_W        : width of the refill performance counter
//   - sat_inc()    : saturating increment for the refill counter
// -----------------------------------------------------------------------------
package mm_refill_responder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2,
      ST_COOL = 2'd3
   } state_e;

   localparam int BLOCK_WORDS = 2;
   localparam int CNT_W       = 20;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   // Counter sticks at all-ones instead of wrapping back to zero.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      logic [CNT_W-1:0] r;
      if (v == CNT_MAX) begin
         r = v;
      end else begin
         r = v + CNT_W'(1);
      end
      return r;
   endfunction

endpackage

// File: rtl/mm_refill_responder_ram.sv
// -----------------------------------------------------------------------------
// mm_word_ram
//   MEM_WORDS x 32-bit word memory with one synchronous write port and two
//   asynchronous read ports that return the even/odd word of a 2-word block.
//   Because reads are combinational and the caller registers them on the same
//   edge a write lands, a colliding write is seen as read-before-write.
//   No reset: contents survive RESET.
// Ports
//   CLK      in   clock, rising edge
//   we_i     in   write enable
//   waddr_i  in   write word index
//   wdata_i  in   write data
//   blk_i    in   block index (word index without its LSB)
//   word0_o  out  mem[{blk_i,0}]
//   word1_o  out  mem[{blk_i,1}]
// -----------------------------------------------------------------------------
module mm_word_ram
   import mm_refill_responder_pkg::*;
#(
   parameter int MEM_WORDS = 256,
   parameter int ADDR_W    = 8
) (
   input  logic              CLK,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [31:0]       wdata_i,
   input  logic [ADDR_W-2:0] blk_i,
   output logic [31:0]       word0_o,
   output logic [31:0]       word1_o
);

   logic [31:0] mem_q [MEM_WORDS];

   logic [ADDR_W-1:0] idx0_s;
   logic [ADDR_W-1:0] idx1_s;

   // Word-level preload / write port.
   always_ff @(posedge CLK) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Block base is always even-word aligned; the two words differ only in the LSB.
   assign idx0_s  = {blk_i, 1'b0};
   assign idx1_s  = {blk_i, 1'b1};
   assign word0_o = mem_q[idx0_s];
   assign word1_o = mem_q[idx1_s];

endmodule

// File: rtl/mm_refill_responder.sv
// -----------------------------------------------------------------------------
// mm_refill_responder
//   Main-memory side of the instruction-cache refill handshake. On a miss it
//   latches the 2-word block containing PC, waits LATENCY cycles, then returns
//   the block on Data_MM with a single-cycle Access_MM strobe. A COOL cycle
//   follows each response so the cache's stale registered miss is not taken
//   as a new request. Completed refills are counted (saturating).
// Parameters
//   MEM_WORDS  memory depth in words (power of two, >= 4)
//   ADDR_W     log2(MEM_WORDS)
//   LATENCY    WAIT cycles before the response, 1..15
// Ports
//   CLK         in   clock, rising edge
//   RESET       in   asynchronous active-high reset
//   Miss_Req    in   miss request from the cache
//   PC          in   byte address of the missing instruction
//   Load_EN     in   memory preload write enable
//   Load_Addr   in   preload word index
//   Load_Data   in   preload data
//   Access_MM   out  one-cycle strobe, Data_MM valid
//   Data_MM     out  refill block {word at base+4, word at base}
//   Busy        out  high in WAIT, RESP and COOL
//   CNT_REFILL  out  completed refill count
// -----------------------------------------------------------------------------
module mm_refill_responder
   import mm_refill_responder_pkg::*;
#(
   parameter int MEM_WORDS = 256,
   parameter int ADDR_W    = 8,
   parameter int LATENCY   = 4
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              Miss_Req,
   input  logic [31:0]       PC,
   input  logic              Load_EN,
   input  logic [ADDR_W-1:0] Load_Addr,
   input  logic [31:0]       Load_Data,
   output logic              Access_MM,
   output logic [63:0]       Data_MM,
   output logic              Busy,
   output logic [CNT_W-1:0]  CNT_REFILL
);

   localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);

   state_e             state_q, state_d;
   logic [3:0]         lat_q, lat_d;
   logic [ADDR_W-2:0]  blk_q, blk_d;
   logic               access_q, access_d;
   logic [63:0]        data_q, data_d;
   logic               busy_q, busy_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic [31:0]        word0_s;
   logic [31:0]        word1_s;

   // Byte offset and address bits above the memory depth do not select a block.
   logic               unused_pc_s;
   assign unused_pc_s = ^{PC[31:ADDR_W+2], PC[2:0]};

   mm_word_ram #(
      .MEM_WORDS (MEM_WORDS),
      .ADDR_W    (ADDR_W)
   ) u_ram (
      .CLK     (CLK),
      .we_i    (Load_EN),
      .waddr_i (Load_Addr),
      .wdata_i (Load_Data),
      .blk_i   (blk_q),
      .word0_o (word0_s),
      .word1_o (word1_s)
   );

   // Next-state and next-output logic for the refill FSM.
   always_comb begin
      state_d  = state_q;
      lat_d    = lat_q;
      blk_d    = blk_q;
      access_d = 1'b0;
      data_d   = data_q;
      cnt_d    = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (Miss_Req) begin
               // PC is captured only here; later PC changes cannot alter the block.
               blk_d   = PC[ADDR_W+1:3];
               lat_d   = LAT_LOAD;
               state_d = ST_WAIT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (lat_q == 4'd0) begin
               data_d   = {word1_s, word0_s};
               access_d = 1'b1;
               state_d  = ST_RESP;
            end else begin
               lat_d    = lat_q - 4'd1;
            end
         end
         ST_RESP: begin
            // Counting on RESP exit means a reset during WAIT/RESP never counts.
            cnt_d   = sat_inc(cnt_q);
            state_d = ST_COOL;
         end
         ST_COOL: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State and registered outputs; memory is deliberately outside this reset.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q  <= ST_IDLE;
         lat_q    <= 4'd0;
         blk_q    <= '0;
         access_q <= 1'b0;
         data_q   <= 64'd0;
         busy_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         lat_q    <= lat_d;
         blk_q    <= blk_d;
         access_q <= access_d;
         data_q   <= data_d;
         busy_q   <= busy_d;
         cnt_q    <= cnt_d;
      end
   end

   assign Access_MM  = access_q;
   assign Data_MM    = data_q;
   assign Busy       = busy_q;
   assign CNT_REFILL = cnt_q;

endmodule
